// File: rtl/mbist_def.sv
// Shared definitions for the MBIST march controller: FSM states and the March C- element table.
package mbist_def;

    typedef enum logic [1:0] {
        StIdle,
        StMarch,
        StNextPat,
        StDone
    } bist_state_e;

    localparam int unsigned MarchElems = 6;

    // op0 is a read except in E0. op1, when present, is always a write.
    typedef struct packed {
        logic two_ops;
        logic op0_we;
        logic op0_inv;
        logic op1_inv;
        logic dir_down;
    } march_elem_t;

    localparam march_elem_t [MarchElems-1:0] MarchTbl = {
        march_elem_t'{two_ops: 1'b0, op0_we: 1'b0, op0_inv: 1'b0, op1_inv: 1'b0, dir_down: 1'b0},
        march_elem_t'{two_ops: 1'b1, op0_we: 1'b0, op0_inv: 1'b1, op1_inv: 1'b0, dir_down: 1'b1},
        march_elem_t'{two_ops: 1'b1, op0_we: 1'b0, op0_inv: 1'b0, op1_inv: 1'b1, dir_down: 1'b1},
        march_elem_t'{two_ops: 1'b1, op0_we: 1'b0, op0_inv: 1'b1, op1_inv: 1'b0, dir_down: 1'b0},
        march_elem_t'{two_ops: 1'b1, op0_we: 1'b0, op0_inv: 1'b0, op1_inv: 1'b1, dir_down: 1'b0},
        march_elem_t'{two_ops: 1'b0, op0_we: 1'b1, op0_inv: 1'b0, op1_inv: 1'b0, dir_down: 1'b0}
    };

    function automatic logic op_is_write(march_elem_t elem, logic op);
        return op ? 1'b1 : elem.op0_we;
    endfunction

    function automatic logic op_is_inv(march_elem_t elem, logic op);
        return op ? elem.op1_inv : elem.op0_inv;
    endfunction

endpackage

// File: rtl/mbist_addr_gen.sv
// Loadable up/down address counter bounded by the tested address window.
module mbist_addr_gen #(
    parameter int unsigned                BIST_ADDR_WD    = 9,
    parameter logic [BIST_ADDR_WD-1:0]    BIST_ADDR_START = 9'h000,
    parameter logic [BIST_ADDR_WD-1:0]    BIST_ADDR_END   = 9'h1F8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load_start_i,
    input  logic                    load_end_i,
    input  logic                    dir_i,
    input  logic                    step_i,
    output logic [BIST_ADDR_WD-1:0] addr_o,
    output logic                    at_last_o
);

    logic [BIST_ADDR_WD-1:0] addr_q;

    // dir_i=1 walks down toward START, otherwise up toward END.
    assign at_last_o = dir_i ? (addr_q == BIST_ADDR_START) : (addr_q == BIST_ADDR_END);
    assign addr_o    = addr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= BIST_ADDR_START;
        end else if (load_start_i) begin
            addr_q <= BIST_ADDR_START;
        end else if (load_end_i) begin
            addr_q <= BIST_ADDR_END;
        end else if (step_i && !at_last_o) begin
            addr_q <= dir_i ? addr_q - BIST_ADDR_WD'(1) : addr_q + BIST_ADDR_WD'(1);
        end
    end

endmodule

// File: rtl/mbist_march_ctrl.sv
// March C- sequencer: drives memory ops and compare strobes, steps patterns, records first error.
module mbist_march_ctrl
    import mbist_def::*;
#(
    parameter int unsigned                BIST_ADDR_WD    = 9,
    parameter logic [BIST_ADDR_WD-1:0]    BIST_ADDR_START = 9'h000,
    parameter logic [BIST_ADDR_WD-1:0]    BIST_ADDR_END   = 9'h1F8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    run_i,
    input  logic                    scan_shift_i,
    input  logic                    pat_last_i,
    input  logic                    cmp_err_i,
    output logic                    pat_run_o,
    output logic                    mem_cs_o,
    output logic                    mem_we_o,
    output logic [BIST_ADDR_WD-1:0] mem_addr_o,
    output logic                    mem_inv_o,
    output logic                    cmp_en_o,
    output logic                    cmp_inv_o,
    output logic                    bist_done_o,
    output logic                    bist_error_o,
    output logic [BIST_ADDR_WD-1:0] bist_err_addr_o
);

    localparam logic [2:0] LastElem = 3'(MarchElems - 1);

    bist_state_e state_q, state_d;
    logic [2:0]  elem_q, elem_d;
    logic        op_q, op_d;
    logic [2:0]  nxt_idx;
    logic        start_run;
    logic        we_d, inv_d;

    logic                    load_start, load_end, addr_dir, addr_step, at_last;
    logic [BIST_ADDR_WD-1:0] addr;

    logic                    mem_cs_q, mem_we_q, mem_inv_q, pat_run_q, bist_done_q;
    logic                    cmp_en_q, cmp_inv_q, bist_error_q;
    logic [BIST_ADDR_WD-1:0] cmp_addr_q, err_addr_q;

    mbist_addr_gen #(
        .BIST_ADDR_WD    (BIST_ADDR_WD),
        .BIST_ADDR_START (BIST_ADDR_START),
        .BIST_ADDR_END   (BIST_ADDR_END)
    ) u_addr_gen (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_start_i (load_start),
        .load_end_i   (load_end),
        .dir_i        (addr_dir),
        .step_i       (addr_step),
        .addr_o       (addr),
        .at_last_o    (at_last)
    );

    always_comb begin
        state_d    = state_q;
        elem_d     = elem_q;
        op_d       = op_q;
        load_start = 1'b0;
        load_end   = 1'b0;
        addr_step  = 1'b0;
        start_run  = 1'b0;
        nxt_idx    = (elem_q == LastElem) ? 3'd0 : elem_q + 3'd1;
        addr_dir   = MarchTbl[elem_q].dir_down;

        if (!run_i || scan_shift_i) begin
            state_d    = StIdle;
            load_start = 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d    = StMarch;
                    elem_d     = 3'd0;
                    op_d       = 1'b0;
                    load_start = 1'b1;
                    start_run  = 1'b1;
                end
                StMarch: begin
                    if (MarchTbl[elem_q].two_ops && !op_q) begin
                        op_d = 1'b1;
                    end else if (!at_last) begin
                        op_d      = 1'b0;
                        addr_step = 1'b1;
                    end else if (elem_q == LastElem) begin
                        state_d = StNextPat;
                        op_d    = 1'b0;
                    end else begin
                        // Next element's start address is loaded here so it issues with no bubble.
                        elem_d     = nxt_idx;
                        op_d       = 1'b0;
                        load_start = !MarchTbl[nxt_idx].dir_down;
                        load_end   = MarchTbl[nxt_idx].dir_down;
                    end
                end
                StNextPat: begin
                    state_d    = pat_last_i ? StDone : StMarch;
                    elem_d     = 3'd0;
                    op_d       = 1'b0;
                    load_start = 1'b1;
                end
                StDone: begin
                    state_d = StDone;
                end
                default: begin
                    state_d    = StIdle;
                    load_start = 1'b1;
                end
            endcase
        end

        we_d  = (state_d == StMarch) && op_is_write(MarchTbl[elem_d], op_d);
        inv_d = (state_d == StMarch) && op_is_inv(MarchTbl[elem_d], op_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            elem_q      <= 3'd0;
            op_q        <= 1'b0;
            mem_cs_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_inv_q   <= 1'b0;
            pat_run_q   <= 1'b0;
            bist_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            elem_q      <= elem_d;
            op_q        <= op_d;
            mem_cs_q    <= (state_d == StMarch);
            mem_we_q    <= we_d;
            mem_inv_q   <= inv_d;
            pat_run_q   <= (state_d == StNextPat);
            bist_done_q <= (state_d == StDone);
        end
    end

    // Compare pipeline keeps running through an abort so an in-flight read still reports.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp_en_q     <= 1'b0;
            cmp_inv_q    <= 1'b0;
            cmp_addr_q   <= '0;
            bist_error_q <= 1'b0;
            err_addr_q   <= '0;
        end else begin
            cmp_en_q   <= mem_cs_q && !mem_we_q;
            cmp_inv_q  <= mem_inv_q;
            cmp_addr_q <= addr;
            if (start_run) begin
                bist_error_q <= 1'b0;
                err_addr_q   <= '0;
            end else if (cmp_en_q && cmp_err_i && !bist_error_q) begin
                bist_error_q <= 1'b1;
                err_addr_q   <= cmp_addr_q;
            end
        end
    end

    assign pat_run_o       = pat_run_q;
    assign mem_cs_o        = mem_cs_q;
    assign mem_we_o        = mem_we_q;
    assign mem_addr_o      = addr;
    assign mem_inv_o       = mem_inv_q;
    assign cmp_en_o        = cmp_en_q;
    assign cmp_inv_o       = cmp_inv_q;
    assign bist_done_o     = bist_done_q;
    assign bist_error_o    = bist_error_q;
    assign bist_err_addr_o = err_addr_q;

endmodule

// File: doc/mbist_march_ctrl.md
Name: mbist_march_ctrl

Overview:
Sequences one MBIST run over a single SRAM using a fixed March C- algorithm:
⇕(w0); ⇑(r0,w1); ⇑(r1,w0); ⇓(r0,w1); ⇓(r1,w0); ⇕(r0).
- "0" means the current data pattern; "1" means its bitwise inverse.
- Generates memory address and op controls, plus read-compare strobes.
- Steps mbist_pat_sel via a one-cycle pat_run pulse after each full march and stops after the last pattern.
- Sits between the MBIST top-level run control, the pattern selector and the memory/compare datapath.

Parameters:
- BIST_ADDR_WD, 9, memory address width.
- BIST_ADDR_START, 9'h000, first tested address.
- BIST_ADDR_END, 9'h1F8, last tested address; must be >= BIST_ADDR_START.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- run  input  1  level; high = execute, low = abort/idle.
- scan_shift  input  1  scan shift active; controller frozen in IDLE.
- pat_last  input  1  current pattern is the last (from mbist_pat_sel).
- cmp_err  input  1  compare mismatch, valid only while cmp_en=1.
- pat_run  output  1  one-cycle pulse advancing the pattern selector.
- mem_cs  output  1  memory access strobe.
- mem_we  output  1  1=write, 0=read; valid while mem_cs=1.
- mem_addr  output  BIST_ADDR_WD  access address.
- mem_inv  output  1  write data is the inverted pattern.
- cmp_en  output  1  read data valid for compare, one cycle after a read.
- cmp_inv  output  1  expected data is the inverted pattern.
- bist_done  output  1  run complete, sticky until run low.
- bist_error  output  1  sticky, any mismatch this run.
- bist_err_addr  output  BIST_ADDR_WD  address of the first mismatch.

Behaviour:
- Reset: all outputs 0; bist_err_addr = 0; state IDLE; mem_addr = BIST_ADDR_START.
- States:
  - IDLE: leaves when run=1 and scan_shift=0.
    - Clears bist_error and bist_err_addr.
    - Loads element index 0 and op index 0.
  - MARCH: one op issued per cycle, mem_cs=1.
  - NEXT_PAT: single cycle, pat_run=1, mem_cs=0.
  - DONE: bist_done=1.
- Per-element op table (op0/op1, direction), held in a package constant:
  - E0 w0 ⇑
  - E1 r0,w1 ⇑
  - E2 r1,w0 ⇑
  - E3 r0,w1 ⇓
  - E4 r1,w0 ⇓
  - E5 r0 ⇑
- Addressing and op stepping:
  - ⇑ elements start at START and increment; ⇓ elements start at END and decrement.
  - Within an address, all ops of the element run on consecutive cycles, then the address steps.
  - Last op at the final address moves to the next element with no bubble.
- mem_inv / cmp_inv are taken from the op's data polarity.
- Read compare:
  - A read issued in cycle N gives cmp_en=1 in cycle N+1.
  - cmp_inv and the registered read address are delayed alongside it.
- Errors:
  - When cmp_en & cmp_err and bist_error=0: bist_error←1 and bist_err_addr←delayed address.
  - Later errors do not overwrite. The run continues (no stop-on-error).
- Pattern stepping:
  - After the last E5 op: MARCH→NEXT_PAT.
  - In NEXT_PAT, pat_last is sampled. If 1: NEXT_PAT→DONE; else NEXT_PAT→MARCH at E0.
  - pat_run pulses in both cases, so the rotating selector returns to pattern 1.
- Cycle count: N = END-START+1 addresses.
  - One pattern = 10N MARCH cycles + 1 NEXT_PAT cycle.
  - The first mem_cs occurs the cycle after run is sampled high in IDLE.
- Abort: run=0 in any state → IDLE next cycle.
  - mem_cs and pat_run are 0 from that cycle, and bist_done clears.
  - A cmp_en already in flight still completes its error capture.
- scan_shift=1 forces IDLE and pat_run=0, same as abort.
- DONE holds until run=0; no restart without run going low.
- Counter widths: address counter is BIST_ADDR_WD bits, compared against the end bound before stepping, so it never wraps.

Decomposition:
- Package mbist_def additions:
  - typedef enum for states.
  - March element count constant (6).
  - Packed element table: op count, op polarities, direction.
- One sub-module, mbist_addr_gen: loadable up/down address counter.
  - Inputs: load_start, load_end, dir, step.
  - Output: at_last flag.

Test Plan:
1. BIST_ADDR_WD=4, START=0, END=3, 2 patterns, cmp_err=0; run rises:
   - 82 cycles (2×41) of controller activity.
   - E0 writes at addresses 0,1,2,3.
   - E3 reads at 3,2,1,0.
   - pat_run pulses at cycles 41 and 82.
   - bist_done=1 and bist_error=0.
2. Same setup, cmp_err=1 on the cmp_en of the E2 read at address 2, and again at address 3:
   - bist_error=1, bist_err_addr=2, run reaches DONE.
3. run dropped in E1 mid-run:
   - Next cycle mem_cs=0 and state IDLE.
   - Re-raising run restarts at E0 address 0; bist_error cleared.
4. scan_shift held high with run=1:
   - No mem_cs and no pat_run.
   - Releasing scan_shift starts at E0 on the next cycle.
5. Assert rst_n low mid-E4:
   - All outputs 0 asynchronously; mem_addr = START.
6. 8 patterns, N=4:
   - Exactly 8 pat_run pulses, the final one with pat_last=1.
   - bist_done asserts the cycle after the 8th pulse.
